// File: rtl/i2c_txn_sequencer.sv
// Turns one register-access request into the full I2C command stream for i2c_master:
// START, address/register/data writes or reads, optional RESTART, STOP; aborts on NACK.
module i2c_txn_sequencer #(
  parameter int unsigned MAX_BYTES = 4
) (
  input  logic                                           clk,
  input  logic                                           rst_n,
  input  logic                                           req_valid,
  output logic                                           req_ready,
  input  logic                                           req_rw,
  input  logic [6:0]                                     req_dev,
  input  logic [7:0]                                     req_reg,
  input  logic [((MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1)-1:0] req_len,
  input  logic [8*MAX_BYTES-1:0]                         wr_data,
  output logic                                           rsp_valid,
  output logic                                           rsp_err,
  output logic [1:0]                                     rsp_err_stage,
  output logic [8*MAX_BYTES-1:0]                         rsp_data,
  output logic                                           busy,
  output logic [2:0]                                     m_cmd,
  output logic [7:0]                                     m_din,
  output logic                                           m_wr,
  input  logic                                           m_ready,
  input  logic                                           m_done,
  input  logic                                           m_ack,
  input  logic [7:0]                                     m_dout
);

  localparam int unsigned CntW  = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
  localparam int unsigned DataW = 8 * MAX_BYTES;

  localparam logic [2:0] CmdStart   = 3'b000;
  localparam logic [2:0] CmdWr      = 3'b001;
  localparam logic [2:0] CmdRd      = 3'b010;
  localparam logic [2:0] CmdStop    = 3'b011;
  localparam logic [2:0] CmdRestart = 3'b100;

  localparam logic [1:0] StageDevW = 2'd0;
  localparam logic [1:0] StageReg  = 2'd1;
  localparam logic [1:0] StageData = 2'd2;
  localparam logic [1:0] StageDevR = 2'd3;

  typedef enum logic [2:0] {
    StIdle,
    StCmd,
    StGuard,
    StWait,
    StEval,
    StResp
  } state_e;

  typedef enum logic [2:0] {
    StepStart,
    StepDevW,
    StepReg,
    StepData,
    StepRestart,
    StepDevR,
    StepRd,
    StepStop
  } step_e;

  state_e            state_q, state_d;
  step_e             step_q, step_d;
  logic [CntW-1:0]   cnt_q, cnt_d;
  logic [CntW-1:0]   len_q, len_d;
  logic              rw_q, rw_d;
  logic [6:0]        dev_q, dev_d;
  logic [7:0]        reg_addr_q, reg_addr_d;
  logic [DataW-1:0]  wdata_q, wdata_d;
  logic              ack_q, ack_d;
  logic [2:0]        m_cmd_q, m_cmd_d;
  logic [7:0]        m_din_q, m_din_d;
  logic              m_wr_q, m_wr_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic              rsp_err_q, rsp_err_d;
  logic [1:0]        rsp_err_stage_q, rsp_err_stage_d;
  logic [DataW-1:0]  rsp_data_q, rsp_data_d;
  logic              busy_q, busy_d;

  logic [2:0]        step_cmd;
  logic [7:0]        step_din;
  logic              last_byte;

  assign last_byte = (cnt_q == len_q);

  // Command and data byte presented to the master for the current step.
  always_comb begin
    step_cmd = CmdStart;
    step_din = 8'h00;
    unique case (step_q)
      StepStart:   step_cmd = CmdStart;
      StepDevW: begin
        step_cmd = CmdWr;
        step_din = {dev_q, 1'b0};
      end
      StepReg: begin
        step_cmd = CmdWr;
        step_din = reg_addr_q;
      end
      StepData: begin
        step_cmd = CmdWr;
        step_din = wdata_q[{cnt_q, 3'b000} +: 8];
      end
      StepRestart: step_cmd = CmdRestart;
      StepDevR: begin
        step_cmd = CmdWr;
        step_din = {dev_q, 1'b1};
      end
      StepRd: begin
        step_cmd = CmdRd;
        step_din = {7'd0, last_byte};
      end
      StepStop:    step_cmd = CmdStop;
      default:     step_cmd = CmdStart;
    endcase
  end

  always_comb begin
    state_d         = state_q;
    step_d          = step_q;
    cnt_d           = cnt_q;
    len_d           = len_q;
    rw_d            = rw_q;
    dev_d           = dev_q;
    reg_addr_d      = reg_addr_q;
    wdata_d         = wdata_q;
    ack_d           = ack_q;
    m_cmd_d         = m_cmd_q;
    m_din_d         = m_din_q;
    m_wr_d          = 1'b0;
    rsp_valid_d     = 1'b0;
    rsp_err_d       = rsp_err_q;
    rsp_err_stage_d = rsp_err_stage_q;
    rsp_data_d      = rsp_data_q;
    busy_d          = busy_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          rw_d            = req_rw;
          dev_d           = req_dev;
          reg_addr_d      = req_reg;
          len_d           = req_len;
          wdata_d         = wr_data;
          rsp_data_d      = '0;
          rsp_err_d       = 1'b0;
          rsp_err_stage_d = 2'd0;
          step_d          = StepStart;
          cnt_d           = '0;
          busy_d          = 1'b1;
          state_d         = StCmd;
        end
      end
      StCmd: begin
        if (m_ready) begin
          m_wr_d  = 1'b1;
          m_cmd_d = step_cmd;
          m_din_d = step_din;
          ack_d   = 1'b0;
          state_d = StGuard;
        end
      end
      // Master ready is still high in the strobe cycle; skip it.
      StGuard: state_d = StWait;
      StWait: begin
        if (m_done) begin
          ack_d = m_ack;
          if (step_q == StepRd) begin
            rsp_data_d[{cnt_q, 3'b000} +: 8] = m_dout;
          end
        end
        if (m_ready) begin
          state_d = StEval;
        end
      end
      StEval: begin
        state_d = StCmd;
        unique case (step_q)
          StepStart: step_d = StepDevW;
          StepDevW: begin
            if (ack_q) begin
              step_d          = StepStop;
              rsp_err_d       = 1'b1;
              rsp_err_stage_d = StageDevW;
              rsp_data_d      = '0;
            end else begin
              step_d = StepReg;
            end
          end
          StepReg: begin
            cnt_d = '0;
            if (ack_q) begin
              step_d          = StepStop;
              rsp_err_d       = 1'b1;
              rsp_err_stage_d = StageReg;
              rsp_data_d      = '0;
            end else begin
              step_d = rw_q ? StepRestart : StepData;
            end
          end
          StepData: begin
            if (ack_q) begin
              step_d          = StepStop;
              rsp_err_d       = 1'b1;
              rsp_err_stage_d = StageData;
              rsp_data_d      = '0;
            end else if (last_byte) begin
              step_d = StepStop;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          StepRestart: step_d = StepDevR;
          StepDevR: begin
            cnt_d = '0;
            if (ack_q) begin
              step_d          = StepStop;
              rsp_err_d       = 1'b1;
              rsp_err_stage_d = StageDevR;
              rsp_data_d      = '0;
            end else begin
              step_d = StepRd;
            end
          end
          // Ack after a read byte is our own ACK/NACK, not the slave's.
          StepRd: begin
            if (last_byte) begin
              step_d = StepStop;
            end else begin
              cnt_d = cnt_q + CntW'(1);
            end
          end
          StepStop: begin
            rsp_valid_d = 1'b1;
            state_d     = StResp;
          end
          default: step_d = StepStop;
        endcase
      end
      StResp: begin
        busy_d  = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= StIdle;
      step_q          <= StepStart;
      cnt_q           <= '0;
      len_q           <= '0;
      rw_q            <= 1'b0;
      dev_q           <= 7'd0;
      reg_addr_q      <= 8'd0;
      wdata_q         <= '0;
      ack_q           <= 1'b0;
      m_cmd_q         <= CmdStart;
      m_din_q         <= 8'd0;
      m_wr_q          <= 1'b0;
      rsp_valid_q     <= 1'b0;
      rsp_err_q       <= 1'b0;
      rsp_err_stage_q <= 2'd0;
      rsp_data_q      <= '0;
      busy_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      step_q          <= step_d;
      cnt_q           <= cnt_d;
      len_q           <= len_d;
      rw_q            <= rw_d;
      dev_q           <= dev_d;
      reg_addr_q      <= reg_addr_d;
      wdata_q         <= wdata_d;
      ack_q           <= ack_d;
      m_cmd_q         <= m_cmd_d;
      m_din_q         <= m_din_d;
      m_wr_q          <= m_wr_d;
      rsp_valid_q     <= rsp_valid_d;
      rsp_err_q       <= rsp_err_d;
      rsp_err_stage_q <= rsp_err_stage_d;
      rsp_data_q      <= rsp_data_d;
      busy_q          <= busy_d;
    end
  end

  assign req_ready     = (state_q == StIdle);
  assign m_cmd         = m_cmd_q;
  assign m_din         = m_din_q;
  assign m_wr          = m_wr_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_err       = rsp_err_q;
  assign rsp_err_stage = rsp_err_stage_q;
  assign rsp_data      = rsp_data_q;
  assign busy          = busy_q;

endmodule

// File: tb/tb_i2c_txn_sequencer.sv
// Bench for i2c_txn_sequencer: behavioural i2c_master model, command and response
// scoreboards fed by directed requests, monitors compare whatever the DUT emits.
module tb_i2c_txn_sequencer;

  localparam logic [2:0] START = 3'b000;
  localparam logic [2:0] WR    = 3'b001;
  localparam logic [2:0] RD    = 3'b010;
  localparam logic [2:0] STOP  = 3'b011;
  localparam logic [2:0] RSTRT = 3'b100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_rw = 1'b0;
  logic [6:0]  req_dev = 7'd0;
  logic [7:0]  req_reg = 8'd0;
  logic [1:0]  req_len = 2'd0;
  logic [31:0] wr_data = 32'd0;
  logic        rsp_valid;
  logic        rsp_err;
  logic [1:0]  rsp_err_stage;
  logic [31:0] rsp_data;
  logic        busy;
  logic [2:0]  m_cmd;
  logic [7:0]  m_din;
  logic        m_wr;
  logic        m_ready = 1'b1;
  logic        m_done = 1'b0;
  logic        m_ack = 1'b0;
  logic [7:0]  m_dout = 8'h00;

  always #5 clk = ~clk;

  i2c_txn_sequencer #(.MAX_BYTES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_rw(req_rw), .req_dev(req_dev),
    .req_reg(req_reg), .req_len(req_len), .wr_data(wr_data),
    .rsp_valid(rsp_valid), .rsp_err(rsp_err), .rsp_err_stage(rsp_err_stage),
    .rsp_data(rsp_data), .busy(busy),
    .m_cmd(m_cmd), .m_din(m_din), .m_wr(m_wr), .m_ready(m_ready), .m_done(m_done),
    .m_ack(m_ack), .m_dout(m_dout)
  );

  int total = 0;
  int bad = 0;
  int rsp_cnt = 0;
  bit rd_seen = 1'b0;

  logic [10:0] exp_cmd[$];
  logic [34:0] exp_rsp[$];
  logic [7:0]  rd_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic pc(input logic [2:0] c, input logic [7:0] d);
    exp_cmd.push_back({c, d});
  endtask

  task automatic pr(input logic err, input logic [1:0] stage, input logic [31:0] data);
    exp_rsp.push_back({err, stage, data});
  endtask

  // Master model: ready stays high through the cycle after the strobe, then is
  // busy for a few cycles; WR/RD finish with done + ready together.
  int         nack_idx = -1;
  int         wr_idx = 0;
  int         mcnt = 0;
  bit         pend = 1'b0;
  logic [2:0] pcmd = START;

  always @(negedge clk) begin
    m_done = 1'b0;
    m_ack  = 1'b0;
    if (!rst_n) begin
      m_ready = 1'b1;
      pend    = 1'b0;
      mcnt    = 0;
    end else if (pend) begin
      pend    = 1'b0;
      m_ready = 1'b0;
      mcnt    = 3;
    end else if (mcnt > 0) begin
      mcnt--;
      if (mcnt == 0) begin
        m_ready = 1'b1;
        if (pcmd == WR) begin
          m_done = 1'b1;
          m_ack  = (wr_idx == nack_idx);
          wr_idx++;
        end else if (pcmd == RD) begin
          m_done = 1'b1;
          m_ack  = 1'b1;
          m_dout = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hEE;
        end
      end
    end else if (m_wr && m_ready) begin
      pend = 1'b1;
      pcmd = m_cmd;
      if (m_cmd == START) wr_idx = 0;
    end
  end

  logic prev_wr = 1'b0;

  always @(posedge clk) begin : mon
    logic [10:0] ec;
    logic [34:0] er;
    #1;
    if (m_wr) begin
      chk("m_wr_needs_ready", {31'd0, m_ready}, 32'd1);
      chk("m_wr_not_back_to_back", {31'd0, prev_wr}, 32'd0);
      if (exp_cmd.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_cmd: got cmd=%0d din=%h want none", m_cmd, m_din);
      end else begin
        ec = exp_cmd.pop_front();
        chk("cmd_din", {21'd0, m_cmd, m_din}, {21'd0, ec});
      end
      if (m_cmd == RD) rd_seen = 1'b1;
    end
    prev_wr = m_wr;
    if (rsp_valid) begin
      rsp_cnt++;
      chk("busy_at_rsp", {31'd0, busy}, 32'd1);
      chk("req_ready_at_rsp", {31'd0, req_ready}, 32'd0);
      if (exp_rsp.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_rsp: got err=%0d data=%h want none", rsp_err, rsp_data);
      end else begin
        er = exp_rsp.pop_front();
        chk("rsp_err", {31'd0, rsp_err}, {31'd0, er[34]});
        chk("rsp_err_stage", {30'd0, rsp_err_stage}, {30'd0, er[33:32]});
        chk("rsp_data", rsp_data, er[31:0]);
      end
    end
  end

  task automatic drive(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [1:0] len, input logic [31:0] wd);
    req_rw  = rw;
    req_dev = dev;
    req_reg = rg;
    req_len = len;
    wr_data = wd;
  endtask

  task automatic issue(input logic rw, input logic [6:0] dev, input logic [7:0] rg,
                       input logic [1:0] len, input logic [31:0] wd, input int nk);
    nack_idx  = nk;
    drive(rw, dev, rg, len, wd);
    req_valid = 1'b1;
    for (int i = 0; i < 200 && !req_ready; i++) @(negedge clk);
    if (!req_ready) begin
      total++;
      bad++;
      $display("FAIL accept_timeout: got req_ready=0 want 1");
    end
    @(negedge clk);
    req_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    for (int i = 0; i < 600 && rsp_cnt < target; i++) @(negedge clk);
    if (rsp_cnt < target) begin
      total++;
      bad++;
      $display("FAIL rsp_timeout: got %0d responses want %0d", rsp_cnt, target);
    end
    @(negedge clk);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_m_wr"}, {31'd0, m_wr}, 32'd0);
    chk({tag, "_m_cmd"}, {29'd0, m_cmd}, 32'd0);
    chk({tag, "_m_din"}, {24'd0, m_din}, 32'd0);
    chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, "_rsp_err"}, {31'd0, rsp_err}, 32'd0);
    chk({tag, "_rsp_err_stage"}, {30'd0, rsp_err_stage}, 32'd0);
    chk({tag, "_rsp_data"}, rsp_data, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_req_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin : stim
    int seen_rdy;
    repeat (2) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write len=0, all ACK.
    pc(START, 8'h00); pc(WR, 8'hA0); pc(WR, 8'h10); pc(WR, 8'hA5); pc(STOP, 8'h00);
    pr(1'b0, 2'd0, 32'h0);
    issue(1'b0, 7'h50, 8'h10, 2'd0, 32'hDEADBEA5, -1);
    chk("busy_after_accept", {31'd0, busy}, 32'd1);
    wait_rsp(1);

    // Read len=1; master-side ack asserted on RD must be ignored.
    rd_q.push_back(8'h3C); rd_q.push_back(8'hC3);
    pc(START, 8'h00); pc(WR, 8'hA0); pc(WR, 8'h20); pc(RSTRT, 8'h00); pc(WR, 8'hA1);
    pc(RD, 8'h00); pc(RD, 8'h01); pc(STOP, 8'h00);
    pr(1'b0, 2'd0, 32'h0000C33C);
    issue(1'b1, 7'h50, 8'h20, 2'd1, 32'h0, -1);
    wait_rsp(2);

    // NACK on device address (write).
    pc(START, 8'h00); pc(WR, 8'hA2); pc(STOP, 8'h00);
    pr(1'b1, 2'd0, 32'h0);
    issue(1'b0, 7'h51, 8'h10, 2'd0, 32'h000000FF, 0);
    wait_rsp(3);

    // NACK on register byte.
    pc(START, 8'h00); pc(WR, 8'hA0); pc(WR, 8'h99); pc(STOP, 8'h00);
    pr(1'b1, 2'd1, 32'h0);
    issue(1'b0, 7'h50, 8'h99, 2'd0, 32'h00000012, 1);
    wait_rsp(4);

    // Write len=2, NACK on second data byte.
    pc(START, 8'h00); pc(WR, 8'hA0); pc(WR, 8'h30); pc(WR, 8'h11); pc(WR, 8'h22);
    pc(STOP, 8'h00);
    pr(1'b1, 2'd2, 32'h0);
    issue(1'b0, 7'h50, 8'h30, 2'd2, 32'h00332211, 3);
    wait_rsp(5);

    // Read with NACK on read-direction address.
    pc(START, 8'h00); pc(WR, 8'hA4); pc(WR, 8'h05); pc(RSTRT, 8'h00); pc(WR, 8'hA5);
    pc(STOP, 8'h00);
    pr(1'b1, 2'd3, 32'h0);
    issue(1'b1, 7'h52, 8'h05, 2'd0, 32'h0, 2);
    wait_rsp(6);

    // Back-to-back: 4-byte read with valid held high and a write queued behind it.
    rd_q.push_back(8'h11); rd_q.push_back(8'h22); rd_q.push_back(8'h33); rd_q.push_back(8'h44);
    pc(START, 8'h00); pc(WR, 8'hD0); pc(WR, 8'h75); pc(RSTRT, 8'h00); pc(WR, 8'hD1);
    pc(RD, 8'h00); pc(RD, 8'h00); pc(RD, 8'h00); pc(RD, 8'h01); pc(STOP, 8'h00);
    pr(1'b0, 2'd0, 32'h44332211);
    pc(START, 8'h00); pc(WR, 8'hA0); pc(WR, 8'h40); pc(WR, 8'h5A); pc(STOP, 8'h00);
    pr(1'b0, 2'd0, 32'h0);
    nack_idx  = -1;
    drive(1'b1, 7'h68, 8'h75, 2'd3, 32'h0);
    req_valid = 1'b1;
    @(negedge clk);
    drive(1'b0, 7'h50, 8'h40, 2'd0, 32'hCAFEBA5A);
    seen_rdy = 0;
    for (int i = 0; i < 600 && !rsp_valid; i++) begin
      if (req_ready) seen_rdy++;
      @(negedge clk);
    end
    chk("req_ready_low_during_read", seen_rdy, 0);
    chk("rsp_valid_seen", {31'd0, rsp_valid}, 32'd1);
    @(negedge clk);
    chk("queued_ready_after_rsp", {31'd0, req_ready}, 32'd1);
    chk("busy_low_after_rsp", {31'd0, busy}, 32'd0);
    @(negedge clk);
    chk("queued_accepted", {31'd0, busy}, 32'd1);
    req_valid = 1'b0;
    wait_rsp(8);

    // Reset in the middle of an RD step, then a clean write.
    rd_seen = 1'b0;
    rd_q.push_back(8'h77); rd_q.push_back(8'h88);
    pc(START, 8'h00); pc(WR, 8'hA0); pc(WR, 8'h22); pc(RSTRT, 8'h00); pc(WR, 8'hA1);
    pc(RD, 8'h00);
    issue(1'b1, 7'h50, 8'h22, 2'd1, 32'h0, -1);
    for (int i = 0; i < 400 && !rd_seen; i++) @(negedge clk);
    chk("rd_step_reached", {31'd0, rd_seen}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    repeat (2) @(negedge clk);
    rd_q.delete();
    chk("midrst_cmds_drained", exp_cmd.size(), 0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pc(START, 8'h00); pc(WR, 8'h78); pc(WR, 8'h01); pc(WR, 8'hE7); pc(STOP, 8'h00);
    pr(1'b0, 2'd0, 32'h0);
    issue(1'b0, 7'h3C, 8'h01, 2'd0, 32'h000000E7, -1);
    wait_rsp(9);

    repeat (5) @(negedge clk);
    chk("exp_cmd_drained", exp_cmd.size(), 0);
    chk("exp_rsp_drained", exp_rsp.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
